switch_debounce_encoder: RTL

//  Front end for the memory-game state machine. Filters bounce on the four raw

---
 rtl/switch_debounce_encoder.sv | 121 ++++++++++++
 1 files changed

// File: rtl/switch_debounce_encoder.sv
// rtl/switch_debounce_encoder.sv - four-switch debouncer with queued release events
// Optional 2-flop input synchronizers enabled by defining DEBOUNCE_SYNC_EN.
module switch_debounce_encoder #(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Switch_1,
    input  logic       i_Switch_2,
    input  logic       i_Switch_3,
    input  logic       i_Switch_4,
    output logic       o_Switch_1,
    output logic       o_Switch_2,
    output logic       o_Switch_3,
    output logic       o_Switch_4,
    output logic       o_Combo,
    output logic       o_Button_DV,
    output logic [1:0] o_Button_ID,
    output logic [3:0] o_Pending
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic [3:0]       raw;
    logic [3:0]       samp;
    logic [3:0]       level;
    logic [3:0]       level_q;
    logic [3:0]       release_ev;
    logic [3:0]       pending;
    logic [3:0]       clr;
    logic [1:0]       next_id;
    logic [CNT_W-1:0] cnt [4];

    assign raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

`ifdef DEBOUNCE_SYNC_EN
    logic [3:0] sync_q1;
    logic [3:0] sync_q2;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
        end
    end

    assign samp = sync_q2;
`else
    assign samp = raw;
`endif

    // Counter only runs while the sample disagrees with the accepted level,
    // so any disagreement shorter than DEBOUNCE_LIMIT cycles is forgotten.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            level <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (samp[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    level[i] <= samp[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign release_ev = level_q & ~level;

    always_comb begin
        clr     = 4'b0000;
        next_id = 2'd0;
        if (pending[0]) begin
            clr     = 4'b0001;
            next_id = 2'd0;
        end else if (pending[1]) begin
            clr     = 4'b0010;
            next_id = 2'd1;
        end else if (pending[2]) begin
            clr     = 4'b0100;
            next_id = 2'd2;
        end else if (pending[3]) begin
            clr     = 4'b1000;
            next_id = 2'd3;
        end
    end

    // A release landing on the bit being reported re-queues it.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            level_q     <= '0;
            o_Combo     <= 1'b0;
            pending     <= '0;
            o_Button_DV <= 1'b0;
            o_Button_ID <= 2'd0;
        end else begin
            level_q     <= level;
            o_Combo     <= level[0] & level[1];
            pending     <= (pending & ~clr) | release_ev;
            o_Button_DV <= |pending;
            o_Button_ID <= next_id;
        end
    end

    assign o_Switch_1 = level[0];
    assign o_Switch_2 = level[1];
    assign o_Switch_3 = level[2];
    assign o_Switch_4 = level[3];
    assign o_Pending  = pending;

endmodule
